// File: rtl/mdu_pkg.sv
// mdu_pkg: shared width, state encoding and constants for the multiply/divide unit
package mdu_pkg;
  localparam int MDU_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  function automatic int cnt_w(int w);
    return $clog2(w) + 1;
  endfunction
  localparam int CNT_W = cnt_w(MDU_WIDTH);
  localparam logic [MDU_WIDTH-1:0] DIVZERO_QUOT = '1;
endpackage

// File: rtl/mdu_cneg.sv
// mdu_cneg: conditional two's-complement negate
module mdu_cneg #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic         neg,
  output logic [N-1:0] y
);
  assign y = neg ? -a : a;
endmodule

// File: rtl/multdiv_seq.sv
// multdiv_seq: iterative signed/unsigned 32-bit multiply and restoring divide, one bit per cycle
module multdiv_seq #(
  parameter int WIDTH = mdu_pkg::MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             multdivb,
  input  logic             signedop,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] prodh,
  output logic [WIDTH-1:0] prodl,
  output logic             run,
  output logic             dividebyzero
);
  import mdu_pkg::*;
  localparam int CW = cnt_w(WIDTH);
  state_t state, nstate;
  logic [2*WIDTH:0] acc, mstep, dstep;
  logic [WIDTH-1:0] b, xm, ym, qfix, rfix;
  logic [2*WIDTH-1:0] pfix;
  logic [WIDTH:0] sum, r, diff;
  logic [CW-1:0] count;
  logic mul, xs, ys, last;
  mdu_cneg #(.N(WIDTH)) u_xm (.a(x), .neg(signedop & x[WIDTH-1]), .y(xm));
  mdu_cneg #(.N(WIDTH)) u_ym (.a(y), .neg(signedop & y[WIDTH-1]), .y(ym));
  mdu_cneg #(.N(2*WIDTH)) u_pf (.a(acc[2*WIDTH-1:0]), .neg(xs ^ ys), .y(pfix));
  mdu_cneg #(.N(WIDTH)) u_qf (.a(acc[WIDTH-1:0]), .neg(xs ^ ys), .y(qfix));
  mdu_cneg #(.N(WIDTH)) u_rf (.a(acc[2*WIDTH-1:WIDTH]), .neg(xs), .y(rfix));
  // Multiply adds into the upper half then shifts right; divide shifts left into a WIDTH+1 trial remainder.
  assign sum   = acc[2*WIDTH:WIDTH] + {1'b0, b};
  assign mstep = {1'b0, acc[0] ? sum : acc[2*WIDTH:WIDTH], acc[WIDTH-1:1]};
  assign r     = acc[2*WIDTH-1:WIDTH-1];
  assign diff  = r - {1'b0, b};
  assign dstep = {diff[WIDTH] ? r : diff, acc[WIDTH-2:0], ~diff[WIDTH]};
  assign last  = count == CW'(WIDTH - 1);
  assign run   = state != IDLE;
  always_comb begin
    nstate = (state == IDLE && start) ? ITER :
             (state == ITER && last)  ? FIX  :
             (state == FIX)           ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= nstate;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      b <= '0;
      mul <= 1'b0;
      xs <= 1'b0;
      ys <= 1'b0;
      count <= '0;
      prodh <= '0;
      prodl <= '0;
      dividebyzero <= 1'b0;
    end else if (state == IDLE && start) begin
      mul <= multdivb;
      xs <= signedop & x[WIDTH-1];
      ys <= signedop & y[WIDTH-1];
      b <= multdivb ? xm : ym;
      acc <= {{(WIDTH+1){1'b0}}, multdivb ? ym : xm};
      count <= '0;
      dividebyzero <= 1'b0;
    end else if (state == ITER) begin
      acc <= mul ? mstep : dstep;
      count <= count + 1'b1;
    end else if (state == FIX) begin
      if (mul) {prodh, prodl} <= pfix;
      else if (b == '0) begin
        prodl <= WIDTH'(DIVZERO_QUOT);
        prodh <= rfix;
        dividebyzero <= 1'b1;
      end else begin
        prodl <= qfix;
        prodh <= rfix;
      end
    end
  end
endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: randomized scoreboard bench for multdiv_seq against a longint reference model
module tb_multdiv_seq;
  logic clk = 0, reset = 1, start = 0, multdivb = 0, signedop = 0;
  logic [31:0] x = 0, y = 0;
  logic [31:0] prodh, prodl;
  logic run, dividebyzero;
  int total = 0, passed = 0;
  logic [64:0] expq[$];
  bit abort_pending = 0;
  multdiv_seq dut (.clk(clk), .reset(reset), .start(start), .multdivb(multdivb),
    .signedop(signedop), .x(x), .y(y), .prodh(prodh), .prodl(prodl), .run(run),
    .dividebyzero(dividebyzero));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask
  function automatic logic [64:0] model(input logic m, input logic s, input logic [31:0] a, input logic [31:0] d);
    longint sa, sd;
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sd = s ? longint'($signed(d)) : longint'({32'b0, d});
    if (m) return {1'b0, 64'(sa * sd)};
    if (d == 0) return {1'b1, a, 32'hFFFFFFFF};
    return {1'b0, 32'(sa % sd), 32'(sa / sd)};
  endfunction
  task automatic issue(input logic m, input logic s, input logic [31:0] a, input logic [31:0] d, input bit push);
    start = 1; multdivb = m; signedop = s; x = a; y = d;
    if (push) expq.push_back(model(m, s, a, d));
    @(negedge clk);
    start = 0; x = $urandom; y = $urandom; multdivb = $urandom_range(0, 1);
    chk("run_after_start", 64'(run), 64'd1);
    chk("dbz_cleared", 64'(dividebyzero), 64'd0);
  endtask
  task automatic wait_idle;
    int n = 0;
    while (run && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (run) begin
      total++;
      $display("FAIL timeout run still high after %0d cycles", n);
    end
  endtask
  task automatic op(input logic m, input logic s, input logic [31:0] a, input logic [31:0] d);
    issue(m, s, a, d, 1);
    wait_idle();
  endtask
  bit prev_run = 0, moved = 0;
  int runlen = 0;
  logic [31:0] hold_h = 0, hold_l = 0;
  logic [64:0] e;
  always @(negedge clk) begin
    if (run) begin
      runlen++;
      if (prodh !== hold_h || prodl !== hold_l) moved = 1;
    end
    if (prev_run && !run) begin
      if (abort_pending) begin
        chk("abort_result", {prodh, prodl}, 64'd0);
        chk("abort_dbz", 64'(dividebyzero), 64'd0);
        abort_pending = 0;
      end else begin
        chk("run_length", 64'(runlen), 64'd33);
        chk("stable_during_run", 64'(moved), 64'd0);
        if (expq.size() == 0) begin
          total++;
          $display("FAIL unexpected_result actual=%h required=none", {prodh, prodl});
        end else begin
          e = expq.pop_front();
          chk("result", {prodh, prodl}, e[63:0]);
          chk("dbz", 64'(dividebyzero), 64'(e[64]));
        end
      end
      runlen = 0;
      moved = 0;
    end
    prev_run = run;
    hold_h = prodh;
    hold_l = prodl;
  end
  initial begin
    logic [31:0] a, d;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("reset_prod", {prodh, prodl}, 64'd0);
    chk("reset_run", 64'(run), 64'd0);
    chk("reset_dbz", 64'(dividebyzero), 64'd0);
    op(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    op(1, 1, 32'hFFFFFFFF, 32'h00000002);
    op(1, 1, 32'h7FFFFFFF, 32'h80000000);
    op(0, 1, 32'hFFFFFFF9, 32'h00000002);
    op(0, 1, 32'h80000000, 32'hFFFFFFFF);
    op(0, 0, 32'h23456789, 32'h00000000);
    op(0, 1, 32'h87654321, 32'h00000000);
    issue(1, 0, 32'h12345678, 32'h9ABCDEF0, 1);
    repeat (9) @(negedge clk);
    start = 1; multdivb = 0; signedop = 1; x = 32'hDEADBEEF; y = 32'h3;
    @(negedge clk);
    start = 0;
    wait_idle();
    issue(1, 1, 32'hCAFEBABE, 32'h1234567, 0);
    repeat (9) @(negedge clk);
    abort_pending = 1;
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort_run", 64'(run), 64'd0);
    issue(1, 0, 32'hABCDEF01, 32'h23456789, 1);
    wait_idle();
    issue(1, 1, 32'hABCDEF01, 32'h23456789, 1);
    wait_idle();
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: d = 0;
        1: d = 32'hFFFFFFFF;
        2: d = $urandom_range(1, 15);
        default: d = $urandom;
      endcase
      issue($urandom_range(0, 1), $urandom_range(0, 1), a, d, 1);
      wait_idle();
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(expq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Iterative 32-bit multiply/divide unit: the responder side of the start/run multiply-divide handshake used by the MIPS datapath and by the module-level multiply/divide benches. It accepts one operation per start pulse and computes signed or unsigned 64-bit products, or quotient/remainder pairs, one bit per cycle. It holds results on prodh/prodl until the next operation completes, so the HI/LO logic can read them after run falls.

## Interface
- WIDTH, 32, operand width; the iteration count equals WIDTH.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- multdivb  in  1  1 = multiply, 0 = divide; captured with start.
- signedop  in  1  1 = two's-complement operands; captured with start.
- x  in  WIDTH  multiplicand / dividend; captured with start.
- y  in  WIDTH  multiplier / divisor; captured with start.
- prodh  out  WIDTH  multiply: upper product; divide: remainder.
- prodl  out  WIDTH  multiply: lower product; divide: quotient.
- run  out  1  high while an operation is in progress.
- dividebyzero  out  1  high when the last completed divide had y = 0; cleared at the next start.

## Operation
- States: IDLE, ITER, FIX.
- IDLE + start:
  - latch multdivb and signedop;
  - latch magnitudes |x| and |y| (two's-complement negate if signedop and MSB set);
  - latch sign bits xs and ys (both 0 if unsigned);
  - count <= 0; run <= 1; dividebyzero <= 0; go to ITER.
- ITER, multiply: radix-2 shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
- ITER, divide: restoring division, one quotient bit per cycle. Trial subtract is WIDTH+1 bits wide; the quotient bit is 1 when the result is non-negative.
- ITER: count increments each cycle; after the WIDTH-th step go to FIX.
- FIX, multiply: {prodh,prodl} <= accumulator, negated as 64 bits if xs^ys.
- FIX, divide:
  - quotient negated if xs^ys;
  - remainder negated if xs (truncating division, remainder takes the dividend's sign).
- FIX, divide with y == 0: skip sign fix-up; prodl <= all ones, prodh <= x as captured, dividebyzero <= 1.
- FIX: run <= 0; go to IDLE.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0, no flag.
- start while run = 1: ignored, with no effect on state or outputs.
- prodh/prodl change only in FIX; they are stable in IDLE and ITER.

## Timing
- Reset values: prodh = 0, prodl = 0, run = 0, dividebyzero = 0, state IDLE, count = 0.
- Reset mid-operation: aborts on the same edge with the reset values above; no partial result is written.
- Edge E0 samples start; run = 1 after E0.
- E1..E32 are the iteration steps. E33 is FIX, where results are written and run falls.
- run is high for exactly WIDTH+1 = 33 cycles; results are valid from the first cycle with run = 0.
- Back-to-back: start may be asserted in the first cycle after run falls and is accepted at the next edge.
- Operand inputs need to be valid only in the start cycle.

## Structure
- Package mdu_pkg:
  - WIDTH default;
  - state enum (IDLE, ITER, FIX);
  - counter width clog2(WIDTH)+1;
  - DIVZERO_QUOT constant (all ones).
- Sub-module mdu_cneg: conditional two's-complement negate, parameterised width. It is instantiated for the operand magnitudes (WIDTH) and for the result fix-up (2·WIDTH for the product, WIDTH for the quotient and remainder).
- Datapath is one 2·WIDTH+1 shift register shared by multiply and divide, plus a WIDTH divisor/multiplicand register and the control FSM.

## Test plan
- Unsigned multiply 0xFFFFFFFF × 0xFFFFFFFF → prodh 0xFFFFFFFE, prodl 0x00000001; run high exactly 33 cycles.
- Signed multiply 0xFFFFFFFF × 0x00000002 → prodh 0xFFFFFFFF, prodl 0xFFFFFFFE.
- Signed multiply 0x7FFFFFFF × 0x80000000 → prodh 0xC0000000, prodl 0x80000000.
- Signed divide:
  - 0xFFFFFFF9 / 0x00000002 → prodl 0xFFFFFFFD, prodh 0xFFFFFFFF;
  - 0x80000000 / 0xFFFFFFFF → prodl 0x80000000, prodh 0, dividebyzero 0.
- Unsigned divide 0x23456789 / 0 → dividebyzero 1, prodl 0xFFFFFFFF, prodh 0x23456789; the flag clears at the next start.
- Reset and back-to-back:
  - start at iteration 10 → ignored, result unchanged;
  - reset at iteration 10 → next cycle run 0, prodh/prodl 0;
  - after that, back-to-back ABCDEF01 × 23456789 unsigned then signed → each result matches a 64-bit reference model.
